// File: rtl/i2c_tx_shifter.sv
// I2C master transmit engine: pops {START, STOP, data[7:0]} words from the TX FIFO and serialises them
// as open-drain SCL/SDA enables. Define I2C_TX_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_tx_shifter #(
    parameter int QTR_DIV  = 250,
    parameter int CNT_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_an,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [9:0] fifo_do,
    output logic       fifo_rd_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       nack,
    input  logic       nack_clr,
    output logic       byte_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ACK,
        S_STOP
    } state_t;

    localparam logic [CNT_BITS-1:0] DIV_LAST = CNT_BITS'(QTR_DIV - 1);

    state_t              state, state_nx;
    logic [CNT_BITS-1:0] div_cnt;
    logic [1:0]          qtr;
    logic [2:0]          bit_idx;
    logic [7:0]          data;
    logic                stop_flag;
    logic                held;
    logic                nack_seen;
    logic                pop, tick, qtr_end, freeze;

`ifdef I2C_TX_CLK_STRETCH_EN
    // Every Q2 releases SCL; a slave still holding it low stalls the quarter.
    assign freeze = (qtr == 2'd2) && !scl_oe && !scl_in;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign freeze     = 1'b0;
`endif

    assign busy    = (state != S_IDLE);
    assign pop     = (state == S_IDLE) && enable && !fifo_empty && !nack;
    assign tick    = busy && !freeze && (div_cnt == DIV_LAST);
    assign qtr_end = tick && (qtr == 2'd3);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        state_nx = state;
        scl_oe   = 1'b0;
        sda_oe   = 1'b0;
        case (state)
            S_IDLE: begin
                scl_oe = held;
                if (pop)
                    state_nx = (fifo_do[9] || !held) ? S_START : S_DATA;
            end
            S_START: begin
                scl_oe = (qtr == 2'd0) ? held : (qtr == 2'd3);
                sda_oe = qtr[1];
                if (qtr_end)
                    state_nx = S_DATA;
            end
            S_DATA: begin
                scl_oe = !qtr[1];
                sda_oe = !data[bit_idx];
                if (qtr_end && bit_idx == 3'd0)
                    state_nx = S_ACK;
            end
            S_ACK: begin
                scl_oe = !qtr[1];
                if (qtr_end)
                    state_nx = (stop_flag || nack_seen) ? S_STOP : S_IDLE;
            end
            S_STOP: begin
                scl_oe = (qtr == 2'd0);
                sda_oe = !qtr[1];
                if (qtr_end)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            qtr       <= 2'd0;
            bit_idx   <= 3'd7;
            data      <= 8'h00;
            stop_flag <= 1'b0;
            held      <= 1'b0;
            nack      <= 1'b0;
            nack_seen <= 1'b0;
            byte_done <= 1'b0;
            fifo_rd_n <= 1'b1;
        end else begin
            state     <= state_nx;
            fifo_rd_n <= !pop;
            byte_done <= qtr_end && (state == S_ACK);

            if (pop) begin
                data      <= fifo_do[7:0];
                stop_flag <= fifo_do[8];
                bit_idx   <= 3'd7;
                nack_seen <= 1'b0;
            end

            if (!busy || tick)
                div_cnt <= '0;
            else if (!freeze)
                div_cnt <= div_cnt + CNT_BITS'(1);

            if (!busy)
                qtr <= 2'd0;
            else if (tick)
                qtr <= qtr + 2'd1;

            if (qtr_end && state == S_DATA)
                bit_idx <= bit_idx - 3'd1;

            if (qtr_end && state == S_START)
                held <= 1'b1;
            else if (qtr_end && state == S_STOP)
                held <= 1'b0;

            // A NACK sampled in the same clk as nack_clr must survive.
            if (tick && state == S_ACK && qtr == 2'd2 && sda_in) begin
                nack      <= 1'b1;
                nack_seen <= 1'b1;
            end else if (nack_clr) begin
                nack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_tx_shifter.sv
// Scoreboard bench for i2c_tx_shifter: a bus monitor decodes START/byte/STOP from the line levels and
// checks them against expectations queued with each FIFO push. Stretch test runs when I2C_TX_CLK_STRETCH_EN is set.
module tb_i2c_tx_shifter;

    localparam int QTR_DIV  = 4;
    localparam int CNT_BITS = 8;

    logic       clk = 1'b0;
    logic       rst_an = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [9:0] fifo_do = 10'h000;
    logic       fifo_rd_n;
    logic       scl_in, sda_in;
    logic       scl_oe, sda_oe;
    logic       busy, nack, byte_done;
    logic       nack_clr = 1'b0;

    always #5 clk = ~clk;

    i2c_tx_shifter #(.QTR_DIV(QTR_DIV), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst_an(rst_an), .enable(enable), .fifo_empty(fifo_empty), .fifo_do(fifo_do),
        .fifo_rd_n(fifo_rd_n), .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .busy(busy), .nack(nack), .nack_clr(nack_clr), .byte_done(byte_done)
    );

    typedef enum logic [1:0] { EV_START, EV_BYTE, EV_STOP } ev_kind_e;
    typedef struct packed { ev_kind_e kind; logic [7:0] data; } ev_t;

    ev_t        exp_q[$];
    logic [9:0] fifo_q[$];

    int n_cmp = 0, n_err = 0;
    int rd_cnt = 0, done_cnt = 0, busy_cyc = 0;

    // Slave / line model state, owned by the monitor.
    int         bitcnt = 0, stretch_cnt = 0;
    logic [7:0] shreg = 8'h00;
    logic       slave_low = 1'b0, started = 1'b0, stretch_done = 1'b0;
    logic       prev_s = 1'b1, prev_d = 1'b1, prev_oe = 1'b0, s_now, d_now;
    logic       slave_nack = 1'b0, stretch_arm = 1'b0;

    assign scl_in = !scl_oe && (stretch_cnt == 0);
    assign sda_in = !sda_oe && !slave_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_event(input ev_kind_e kind, input logic [7:0] dat);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected bus event: got kind %0d data 0x%0h, expected nothing", kind, dat);
        end else begin
            e = exp_q.pop_front();
            check("bus event kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_BYTE)
                check("bus byte", 32'(dat), 32'(e.data));
        end
    endtask

    // FIFO model: pops on a low read strobe at the clock edge.
    always @(posedge clk)
        if (rst_an && !fifo_rd_n && fifo_q.size() > 0)
            void'(fifo_q.pop_front());

    // Monitor: FIFO outputs, I2C line decode, slave ACK/stretch, event counters.
    always @(negedge clk) begin
        fifo_empty = (fifo_q.size() == 0);
        fifo_do    = fifo_empty ? 10'h000 : fifo_q[0];
        if (stretch_cnt > 0)
            stretch_cnt = stretch_cnt - 1;
        if (!rst_an) begin
            bitcnt      = 0;
            slave_low   = 1'b0;
            started     = 1'b0;
            stretch_cnt = 0;
            prev_s      = 1'b1;
            prev_d      = 1'b1;
            prev_oe     = 1'b0;
        end else begin
            if (stretch_arm && !stretch_done && started && bitcnt == 0 && prev_oe && !scl_oe) begin
                stretch_cnt  = 20;
                stretch_done = 1'b1;
            end
            s_now = !scl_oe && (stretch_cnt == 0);
            d_now = !sda_oe && !slave_low;
            if (prev_s && s_now && prev_d && !d_now) begin
                sb_event(EV_START, 8'h00);
                bitcnt  = 0;
                started = 1'b1;
            end else if (prev_s && s_now && !prev_d && d_now) begin
                sb_event(EV_STOP, 8'h00);
                bitcnt  = 0;
                started = 1'b0;
            end
            if (!prev_s && s_now) begin
                if (bitcnt < 8) begin
                    shreg  = {shreg[6:0], d_now};
                    bitcnt = bitcnt + 1;
                    if (bitcnt == 8)
                        sb_event(EV_BYTE, shreg);
                end else if (bitcnt == 8) begin
                    bitcnt = 9;
                end
            end
            if (prev_s && !s_now) begin
                if (bitcnt == 8) begin
                    slave_low = !slave_nack;
                end else if (bitcnt == 9) begin
                    slave_low = 1'b0;
                    bitcnt    = 0;
                end
            end
            prev_s  = s_now;
            prev_d  = !sda_oe && !slave_low;
            prev_oe = scl_oe;
            if (!fifo_rd_n) rd_cnt++;
            if (byte_done)  done_cnt++;
            if (busy)       busy_cyc++;
        end
    end

    task automatic send(input logic [9:0] w, input bit exp_start, input bit exp_stop);
        if (exp_start) exp_q.push_back('{EV_START, 8'h00});
        exp_q.push_back('{EV_BYTE, w[7:0]});
        if (exp_stop) exp_q.push_back('{EV_STOP, 8'h00});
        fifo_q.push_back(w);
    endtask

    task automatic wait_done(input string name, input int budget);
        int quiet = 0;
        for (int i = 0; i < budget && quiet < 8; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        check({name, " completes"}, 32'(quiet >= 8), 32'd1);
    endtask

    int rd0, done0, busy0;
    bit found;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset scl_oe", 32'(scl_oe), 32'd0);
        check("reset sda_oe", 32'(sda_oe), 32'd0);
        check("reset fifo_rd_n", 32'(fifo_rd_n), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset nack", 32'(nack), 32'd0);
        check("reset byte_done", 32'(byte_done), 32'd0);
        rst_an = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // T1: single word 0x3A5, ACKed, 44 quarters of 4 clk
        rd0 = rd_cnt; done0 = done_cnt; busy0 = busy_cyc;
        send(10'h3A5, 1'b1, 1'b1);
        wait_done("t1", 2000);
        check("t1 pops", 32'(rd_cnt - rd0), 32'd1);
        check("t1 byte_done", 32'(done_cnt - done0), 32'd1);
        check("t1 busy cycles", 32'(busy_cyc - busy0), 32'd176);
        check("t1 nack", 32'(nack), 32'd0);
        check("t1 idle scl_oe", 32'(scl_oe), 32'd0);
        check("t1 idle sda_oe", 32'(sda_oe), 32'd0);

        // T2: 0x255 then 0x1AA back to back, SCL held between
        rd0 = rd_cnt; done0 = done_cnt;
        send(10'h255, 1'b1, 1'b0);
        send(10'h1AA, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (byte_done) found = 1'b1;
        end
        check("t2 first byte_done seen", 32'(found), 32'd1);
        check("t2 gap busy", 32'(busy), 32'd0);
        check("t2 gap scl held", 32'(scl_oe), 32'd1);
        check("t2 gap sda_oe", 32'(sda_oe), 32'd0);
        wait_done("t2", 2000);
        check("t2 pops", 32'(rd_cnt - rd0), 32'd2);
        check("t2 byte_done", 32'(done_cnt - done0), 32'd2);
        check("t2 idle scl_oe", 32'(scl_oe), 32'd0);

        // T3: NACK on 0x201 forces STOP; queued 0x1F0 waits for nack_clr, then gets a forced START
        rd0 = rd_cnt; done0 = done_cnt;
        slave_nack = 1'b1;
        send(10'h201, 1'b1, 1'b1);
        fifo_q.push_back(10'h1F0);
        wait_done("t3 nack word", 2000);
        repeat (100) @(negedge clk);
        check("t3 nack set", 32'(nack), 32'd1);
        check("t3 pops while nack", 32'(rd_cnt - rd0), 32'd1);
        check("t3 fifo level", 32'(fifo_q.size()), 32'd1);
        check("t3 busy while nack", 32'(busy), 32'd0);
        slave_nack = 1'b0;
        exp_q.push_back('{EV_START, 8'h00});
        exp_q.push_back('{EV_BYTE, 8'hF0});
        exp_q.push_back('{EV_STOP, 8'h00});
        nack_clr = 1'b1;
        @(negedge clk);
        nack_clr = 1'b0;
        check("t3 nack cleared", 32'(nack), 32'd0);
        wait_done("t3 retry", 2000);
        check("t3 pops total", 32'(rd_cnt - rd0), 32'd2);
        check("t3 byte_done total", 32'(done_cnt - done0), 32'd2);
        check("t3 nack after retry", 32'(nack), 32'd0);

        // T4: 0x0C3 without START on an idle bus still gets a START; bus left held
        send(10'h0C3, 1'b1, 1'b0);
        wait_done("t4", 2000);
        check("t4 scl held", 32'(scl_oe), 32'd1);
        check("t4 sda_oe", 32'(sda_oe), 32'd0);

        // T5: reset during DATA bit 3 releases both lines immediately
        fifo_q.push_back(10'h066);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (bitcnt == 3) found = 1'b1;
        end
        check("t5 reached bit 3", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (scl_oe) found = 1'b1;
        end
        check("t5 bit 3 low phase", 32'(found), 32'd1);
        check("t5 busy before reset", 32'(busy), 32'd1);
        rst_an = 1'b0;
        #1;
        check("t5 reset scl_oe", 32'(scl_oe), 32'd0);
        check("t5 reset sda_oe", 32'(sda_oe), 32'd0);
        check("t5 reset busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_an = 1'b1;
        rd0 = rd_cnt;
        repeat (60) @(negedge clk);
        check("t5 no pop when empty", 32'(rd_cnt - rd0), 32'd0);
        check("t5 busy after reset", 32'(busy), 32'd0);
        check("t5 scl released", 32'(scl_oe), 32'd0);

`ifdef I2C_TX_CLK_STRETCH_EN
        // T6: slave stretches bit 0 Q2 by 20 clk
        done0 = done_cnt; busy0 = busy_cyc;
        stretch_arm = 1'b1;
        send(10'h3A5, 1'b1, 1'b1);
        wait_done("t6", 3000);
        check("t6 stretch applied", 32'(stretch_done), 32'd1);
        check("t6 busy cycles", 32'(busy_cyc - busy0), 32'd196);
        check("t6 byte_done", 32'(done_cnt - done0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_tx_shifter.md
Name: i2c_tx_shifter

Overview:
- Single-clock I2C master transmit engine on the read side of the I2C transmit FIFO.
- Pops 10-bit words (bit9 START, bit8 STOP, bits7:0 data) and serialises them MSB-first as open-drain SCL/SDA enables.
- Samples the slave ACK on the 9th clock and reports NACK.

Parameters:
QTR_DIV, 250, clk cycles per quarter-bit (100 MHz clk -> 100 kHz SCL); legal 2..2^CNT_BITS-1
CNT_BITS, 8, width of the quarter-bit divider counter

Ports:
clk  input  1  block clock; also the FIFO rd_clk
rst_an  input  1  asynchronous active-low reset
enable  input  1  permits new FIFO pops when 1
fifo_empty  input  1  FIFO empty flag
fifo_do  input  10  FIFO read data; valid combinationally while fifo_empty=0
fifo_rd_n  output  1  FIFO read strobe, active low, one clk wide per pop
scl_in  input  1  synchronised SCL line level
sda_in  input  1  synchronised SDA line level
scl_oe  output  1  1 = drive SCL low
sda_oe  output  1  1 = drive SDA low
busy  output  1  1 whenever state is not IDLE
nack  output  1  sticky NACK flag
nack_clr  input  1  clears nack (one clk pulse)
byte_done  output  1  one-clk pulse after the ACK phase of each byte

Behaviour:
- Reset: state IDLE; scl_oe=0, sda_oe=0, fifo_rd_n=1, busy=0, nack=0, byte_done=0; divider=0; held=0. Reset mid-byte releases both lines immediately, with no STOP.
- Divider: counts 0..QTR_DIV-1 outside IDLE and generates a one-clk tick at QTR_DIV-1. It clears to 0 on every IDLE exit. Each phase Q0..Q3 lasts exactly one tick period.
- Pop (IDLE only): when enable=1, fifo_empty=0 and nack=0:
  - drive fifo_rd_n=0 for exactly 1 clk;
  - latch fifo_do into word register in the same clk;
  - go to START if word[9]=1 or held=0 (a missing START on an idle bus is forced to START), else go to DATA.
- START: Q0 scl_oe=held, sda_oe=0; Q1 scl_oe=0; Q2 sda_oe=1; Q3 scl_oe=1. Then held=1.
- DATA: 8 bits, MSB first. Per bit:
  - Q0/Q1: scl_oe=1, sda_oe=~bit;
  - Q2/Q3: scl_oe=0.
- ACK: Q0/Q1 scl_oe=1, sda_oe=0 (released). Q2 scl_oe=0. On the tick ending Q2, sample sda_in; 1 sets nack.
- byte_done: pulses 1 clk on the tick ending ACK Q3.
- After ACK, go to STOP if word[8]=1 or a NACK was sampled; otherwise go to IDLE with held=1 and scl_oe=1 (SCL kept low).
- STOP: Q0 scl_oe=1, sda_oe=1; Q1 scl_oe=0; Q2 sda_oe=0; Q3 both 0. Then held=0 and return to IDLE.
- IDLE outputs: scl_oe=held, sda_oe=0.
- nack: set by NACK, cleared by nack_clr. If both occur in the same clk, set wins. While nack=1, no pops occur.
- enable=0: the current word completes; only new pops are inhibited. A held bus stays held.
- fifo_empty=1 while held=1: wait in IDLE indefinitely with SCL low.
- Back-to-back words with no STOP: the next pop may occur in the clk after the return to IDLE.

Optional Feature:
I2C_TX_CLK_STRETCH_EN
- Defined: in any Q2 with scl_oe=0, the divider freezes while scl_in=0. Q2 starts counting only after scl_in reads 1 (slave clock stretching).
- Undefined: scl_in is ignored and timing is purely divider-based.

Test Plan:
- QTR_DIV=4; push 0x3A5 (START, STOP, data A5); slave ACKs -> exactly one fifo_rd_n low pulse; SDA bits 1,0,1,0,0,1,0,1; one byte_done; STOP; nack=0; idle with both oe=0 after 4+32+4+4 quarter periods.
- Push 0x255 then 0x1AA -> START, 55, SCL held low between words, no second START, AA, STOP; two byte_done pulses.
- Slave NACKs word 0x201 (no STOP bit) -> nack=1, STOP issued; a further queued word is not popped until nack_clr, then is sent with a forced START.
- Push 0x0C3 (no START) on an idle bus -> START generated anyway.
- Assert rst_an=0 during DATA bit 3 -> scl_oe=sda_oe=0 and busy=0 immediately; no fifo_rd_n pulse after reset release while fifo_empty=1.
- With I2C_TX_CLK_STRETCH_EN: hold scl_in=0 for 20 clk in bit 0 Q2 -> that bit lengthens by 20 clk; data still correct.
